// File: rtl/cordic_vec.sv
// Iterative vectoring-mode CORDIC: signed (x, y) to uncompensated magnitude and
// 18-bit angle (360 deg = 2^18), one micro-rotation per clock, start/done handshake.
module cordic_vec #(
    parameter int unsigned WIDTH    = 18,
    parameter int unsigned ITER_NUM = 16
) (
    input  logic               sys_clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   x_i,
    input  logic [WIDTH-1:0]   y_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH:0]     mag_o,
    output logic [WIDTH-1:0]   theta_o
);

    localparam int unsigned IW    = WIDTH + 2;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VEC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                state_q;
    logic signed [IW-1:0]  x_q;
    logic signed [IW-1:0]  y_q;
    logic [WIDTH-1:0]      z_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  zero_q;

    logic signed [IW-1:0]  x_ext_c;
    logic signed [IW-1:0]  y_ext_c;
    logic signed [IW-1:0]  x_sh_c;
    logic signed [IW-1:0]  y_sh_c;
    logic [WIDTH-1:0]      atan_c;

    // Sign extension of the inputs, shifted operands and arctangent lookup.
    always_comb begin
        x_ext_c = {{2{x_i[WIDTH-1]}}, x_i};
        y_ext_c = {{2{y_i[WIDTH-1]}}, y_i};
        x_sh_c  = x_q >>> idx_q;
        y_sh_c  = y_q >>> idx_q;
        case (idx_q)
            4'd0:    atan_c = WIDTH'('h8000);
            4'd1:    atan_c = WIDTH'('h4B90);
            4'd2:    atan_c = WIDTH'('h27ED);
            4'd3:    atan_c = WIDTH'('h1444);
            4'd4:    atan_c = WIDTH'('hA2C);
            4'd5:    atan_c = WIDTH'('h517);
            4'd6:    atan_c = WIDTH'('h28C);
            4'd7:    atan_c = WIDTH'('h146);
            4'd8:    atan_c = WIDTH'('hA3);
            4'd9:    atan_c = WIDTH'('h51);
            4'd10:   atan_c = WIDTH'('h29);
            4'd11:   atan_c = WIDTH'('h14);
            4'd12:   atan_c = WIDTH'('hA);
            4'd13:   atan_c = WIDTH'('h5);
            4'd14:   atan_c = WIDTH'('h3);
            default: atan_c = WIDTH'('h1);
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            idx_q   <= '0;
            zero_q  <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            mag_o   <= '0;
            theta_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        // Fold the left half-plane onto the right, pre-loading 180 deg.
                        if (x_i[WIDTH-1]) begin
                            x_q <= -x_ext_c;
                            y_q <= -y_ext_c;
                            z_q <= WIDTH'(1 << (WIDTH - 1));
                        end else begin
                            x_q <= x_ext_c;
                            y_q <= y_ext_c;
                            z_q <= '0;
                        end
                        zero_q  <= (x_i == '0) && (y_i == '0);
                        idx_q   <= '0;
                        busy_o  <= 1'b1;
                        state_q <= ST_VEC;
                    end
                end
                ST_VEC: begin
                    if (!y_q[IW-1]) begin
                        x_q <= x_q + y_sh_c;
                        y_q <= y_q - x_sh_c;
                        z_q <= z_q + atan_c;
                    end else begin
                        x_q <= x_q - y_sh_c;
                        y_q <= y_q + x_sh_c;
                        z_q <= z_q - atan_c;
                    end
                    if (idx_q == IDX_W'(ITER_NUM - 1)) begin
                        state_q <= ST_OUT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_OUT: begin
                    // x cannot go negative after folding; the sign guard only clamps.
                    if (zero_q || x_q[IW-1]) begin
                        mag_o <= '0;
                    end else begin
                        mag_o <= x_q[WIDTH:0];
                    end
                    theta_o <= zero_q ? '0 : z_q;
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vec.sv
// Directed-vector bench for cordic_vec: angle/magnitude tables, latency, busy
// width, start handling while busy, back-to-back starts and mid-run reset.
module tb_cordic_vec;

    localparam int unsigned WIDTH    = 18;
    localparam int unsigned ITER_NUM = 16;
    localparam int          LAT      = ITER_NUM + 1;

    logic               clk;
    logic               reset_i;
    logic               start_i;
    logic [WIDTH-1:0]   x_i;
    logic [WIDTH-1:0]   y_i;
    logic               busy_o;
    logic               done_o;
    logic [WIDTH:0]     mag_o;
    logic [WIDTH-1:0]   theta_o;

    int n_vec;
    int n_bad;

    cordic_vec #(.WIDTH(WIDTH), .ITER_NUM(ITER_NUM)) dut (
        .sys_clk_i (clk),
        .reset_i   (reset_i),
        .start_i   (start_i),
        .x_i       (x_i),
        .y_i       (y_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .mag_o     (mag_o),
        .theta_o   (theta_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int theta;
        int mag;
    } vec_t;

    task automatic check(input string name, input bit ok, input int act, input int exp);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit angle_ok(input int act, input int exp);
        int d;
        d = (act - exp) & 32'h3FFFF;
        if (d > 131072) d = d - 262144;
        return (d <= 16) && (d >= -16);
    endfunction

    function automatic bit mag_ok(input int act, input int exp);
        int tol;
        tol = exp / 1000;
        return (act <= exp + tol) && (act >= exp - tol);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion; returns cycles from accept edge to done and busy-high cycles.
    task automatic convert(input int x, input int y, output int lat, output int busy_cnt,
                           output bit busy_in_done);
        x_i     = WIDTH'(x);
        y_i     = WIDTH'(y);
        start_i = 1'b1;
        tick();
        start_i  = 1'b0;
        x_i      = ~x_i;
        y_i      = ~y_i;
        lat      = 0;
        busy_cnt = 0;
        while (!done_o && lat < 40) begin
            if (busy_o) busy_cnt++;
            tick();
            lat++;
        end
        busy_in_done = busy_o;
    endtask

    vec_t vecs[12];

    initial begin
        int lat, bcnt, ndone, t1, t2, cyc;
        bit bdone;
        int hold_mag, hold_theta;

        n_vec   = 0;
        n_bad   = 0;
        reset_i = 1'b1;
        start_i = 1'b0;
        x_i     = '0;
        y_i     = '0;

        vecs[0]  = '{ 65536,       0,      0, 107921};
        vecs[1]  = '{     0,   65536,  65536, 107921};
        vecs[2]  = '{     0,  -65536, 196608, 107921};
        vecs[3]  = '{-65536,  -65536, 163840, 152625};
        vecs[4]  = '{ 65536,  -65536, 229376, 152625};
        vecs[5]  = '{-65536,   65536,  98304, 152625};
        vecs[6]  = '{ 65536,   65536,  32768, 152625};
        vecs[7]  = '{-131072, -131072, 163840, 305253};
        vecs[8]  = '{-131072,       0, 131072, 215842};
        vecs[9]  = '{     0, -131072, 196608, 215842};
        vecs[10] = '{ 131071,  131071,  32768, 305251};
        vecs[11] = '{-65536,        0, 131072, 107921};

        repeat (3) tick();
        check("reset_mag",   mag_o == '0,   int'(mag_o),   0);
        check("reset_theta", theta_o == '0, int'(theta_o), 0);
        check("reset_busy",  busy_o == 1'b0, int'(busy_o), 0);
        check("reset_done",  done_o == 1'b0, int'(done_o), 0);
        reset_i = 1'b0;
        tick();

        foreach (vecs[i]) begin
            convert(vecs[i].x, vecs[i].y, lat, bcnt, bdone);
            check($sformatf("v%0d_latency", i), lat == LAT, lat, LAT);
            check($sformatf("v%0d_busy_cycles", i), bcnt == LAT, bcnt, LAT);
            check($sformatf("v%0d_busy_in_done", i), !bdone, int'(bdone), 0);
            check($sformatf("v%0d_theta", i), angle_ok(int'(theta_o), vecs[i].theta),
                  int'(theta_o), vecs[i].theta);
            check($sformatf("v%0d_mag", i), mag_ok(int'(mag_o), vecs[i].mag),
                  int'(mag_o), vecs[i].mag);
            tick();
            check($sformatf("v%0d_done_pulse", i), done_o == 1'b0, int'(done_o), 0);
        end

        // Outputs hold after done.
        hold_mag   = int'(mag_o);
        hold_theta = int'(theta_o);
        repeat (5) tick();
        check("hold_mag",   int'(mag_o) == hold_mag,     int'(mag_o),   hold_mag);
        check("hold_theta", int'(theta_o) == hold_theta, int'(theta_o), hold_theta);

        // Zero vector.
        convert(0, 0, lat, bcnt, bdone);
        check("zero_latency", lat == LAT, lat, LAT);
        check("zero_mag",   mag_o == '0,   int'(mag_o),   0);
        check("zero_theta", theta_o == '0, int'(theta_o), 0);
        tick();

        // start pulsed while busy is ignored.
        x_i = WIDTH'(0); y_i = WIDTH'(65536); start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        x_i = WIDTH'(65536); y_i = WIDTH'(0); start_i = 1'b1;
        tick();
        start_i = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_o) begin
                ndone++;
                check("busy_start_theta", angle_ok(int'(theta_o), 65536), int'(theta_o), 65536);
            end
            tick();
        end
        check("busy_start_ndone", ndone == 1, ndone, 1);

        // start held high through done: next done 18 cycles later.
        x_i = WIDTH'(-65536); y_i = WIDTH'(-65536); start_i = 1'b1;
        t1 = -1; t2 = -1; cyc = 0;
        while (t2 < 0 && cyc < 60) begin
            tick();
            cyc++;
            if (done_o) begin
                if (t1 < 0) t1 = cyc;
                else        t2 = cyc;
            end
        end
        start_i = 1'b0;
        check("b2b_spacing", (t1 >= 0) && (t2 - t1 == LAT + 1), t2 - t1, LAT + 1);
        check("b2b_theta", angle_ok(int'(theta_o), 163840), int'(theta_o), 163840);
        repeat (25) tick();

        // Reset at iteration 5 aborts; outputs clear.
        check("pre_reset_nonzero", mag_o != '0, int'(mag_o), 152625);
        x_i = WIDTH'(0); y_i = WIDTH'(65536); start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("abort_mag",   mag_o == '0,    int'(mag_o),   0);
        check("abort_theta", theta_o == '0,  int'(theta_o), 0);
        check("abort_busy",  busy_o == 1'b0, int'(busy_o),  0);
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            if (done_o) ndone++;
            tick();
        end
        check("abort_no_done", ndone == 0, ndone, 0);

        // Reset and start together: start is not accepted.
        x_i = WIDTH'(65536); y_i = WIDTH'(0); start_i = 1'b1; reset_i = 1'b1;
        tick();
        start_i = 1'b0; reset_i = 1'b0;
        tick();
        check("rst_start_busy", busy_o == 1'b0, int'(busy_o), 0);
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            if (done_o) ndone++;
            tick();
        end
        check("rst_start_no_done", ndone == 0, ndone, 0);

        // Fresh conversion after reset completes normally.
        convert(65536, -65536, lat, bcnt, bdone);
        check("fresh_latency", lat == LAT, lat, LAT);
        check("fresh_theta", angle_ok(int'(theta_o), 229376), int'(theta_o), 229376);
        check("fresh_mag", mag_ok(int'(mag_o), 152625), int'(mag_o), 152625);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
